// File: rtl/mvm_pkg.sv
// mvm_pkg: shared state encoding and default sizes for the matrix-vector MAC sequencer
package mvm_pkg;
    localparam int MVM_DIM = 8;
    localparam int MVM_DW = 8;
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE} mvm_state_t;
endpackage

// File: rtl/mvm_seq_ctrl_if.sv
// mvm_seq_ctrl_if: host job/load handshake between the host and the sequencer
interface mvm_seq_ctrl_if import mvm_pkg::*; #(
    parameter int DIM = MVM_DIM,
    parameter int DW = MVM_DW
);
    logic start, in_valid, in_ready, busy, done, err;
    logic [DIM*DW-1:0] in_a_data;
    logic [DW-1:0] in_b_data;
    modport master(output start, in_valid, in_a_data, in_b_data, input in_ready, busy, done, err);
    modport slave(input start, in_valid, in_a_data, in_b_data, output in_ready, busy, done, err);
endinterface

// File: rtl/mvm_skew_gen.sv
// mvm_skew_gen: decodes the compute counter into skewed A-row and B read enables
module mvm_skew_gen import mvm_pkg::*; #(
    parameter int DIM = MVM_DIM,
    parameter int CNT_W = $clog2(2*DIM)
) (
    input  mvm_state_t       state,
    input  logic [CNT_W-1:0] k,
    output logic [DIM-1:0]   a_rden,
    output logic             b_rden
);
    for (genvar i = 0; i < DIM; i++) begin : g_rd
        assign a_rden[i] = state == COMPUTE && k >= CNT_W'(i) && k < CNT_W'(i + DIM);
    end
    assign b_rden = state == COMPUTE && k < CNT_W'(DIM);
endmodule

// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl: one-job-per-start sequencer driving FIFO writes/reads and MAC enables/clear
module mvm_seq_ctrl import mvm_pkg::*; #(
    parameter int DIM = MVM_DIM,
    parameter int DATA_WIDTH = MVM_DW,
    parameter int CNT_W = $clog2(2*DIM)
) (
    input  logic                      clk,
    input  logic                      rst,
    mvm_seq_ctrl_if.slave             host,
    input  logic [DIM-1:0]            a_full,
    input  logic [DIM-1:0]            a_empty,
    input  logic                      b_full,
    input  logic                      b_empty,
    output logic                      a_wren,
    output logic [DIM*DATA_WIDTH-1:0] a_wdata,
    output logic                      b_wren,
    output logic [DATA_WIDTH-1:0]     b_wdata,
    output logic [DIM-1:0]            a_rden,
    output logic                      b_rden,
    output logic [DIM-1:0]            mac_en,
    output logic                      mac_clr
);
    localparam logic [CNT_W-1:0] LOAD_END = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] COMP_END = CNT_W'(2*DIM - 2);
    mvm_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic accept, full_hit, empty_hit, err;
    mvm_skew_gen #(.DIM(DIM), .CNT_W(CNT_W)) u_skew (
        .state(state),
        .k(cnt),
        .a_rden(a_rden),
        .b_rden(b_rden)
    );
    assign full_hit = state == LOAD && host.in_valid && (|a_full || b_full);
    assign empty_hit = |(a_rden & a_empty) || (b_rden && b_empty);
    assign host.in_ready = state == LOAD && !full_hit;
    assign accept = host.in_valid && host.in_ready;
    assign a_wren = accept;
    assign b_wren = accept;
    assign a_wdata = accept ? host.in_a_data : '0;
    assign b_wdata = accept ? host.in_b_data : '0;
    assign mac_clr = state == CLEAR;
    assign host.busy = state != IDLE;
    assign host.done = state == DONE;
    assign host.err = err;
    always_comb begin
        state_nxt = state;
        cnt_nxt = cnt;
        case (state)
            IDLE:    state_nxt = host.start ? CLEAR : IDLE;
            CLEAR:   state_nxt = LOAD;
            LOAD: begin
                state_nxt = accept && cnt == LOAD_END ? COMPUTE : LOAD;
                cnt_nxt = !accept ? cnt : cnt == LOAD_END ? '0 : cnt + 1'b1;
            end
            COMPUTE: begin
                state_nxt = cnt == COMP_END ? DRAIN : COMPUTE;
                cnt_nxt = cnt == COMP_END ? '0 : cnt + 1'b1;
            end
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            mac_en <= '0;
            err <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            mac_en <= a_rden;
            err <= state == IDLE && host.start ? ~&a_empty || !b_empty : err || full_hit || empty_hit;
        end
    end
endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// tb_mvm_seq_ctrl: directed jobs checked every cycle against a timeline model of the sequencer
module tb_mvm_seq_ctrl;
    localparam int DIM = 8;
    localparam int DW = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mvm_seq_ctrl_if #(.DIM(DIM), .DW(DW)) host ();
    logic [DIM-1:0] a_full, a_empty, a_rden, mac_en, full_mask;
    logic b_full, b_empty, a_wren, b_wren, b_rden, mac_clr;
    logic [DIM*DW-1:0] a_wdata;
    logic [DW-1:0] b_wdata;
    mvm_seq_ctrl #(.DIM(DIM), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .host(host),
        .a_full(a_full), .a_empty(a_empty), .b_full(b_full), .b_empty(b_empty),
        .a_wren(a_wren), .a_wdata(a_wdata), .b_wren(b_wren), .b_wdata(b_wdata),
        .a_rden(a_rden), .b_rden(b_rden), .mac_en(mac_en), .mac_clr(mac_clr)
    );
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int a_cnt [DIM];
    int b_cnt = 0;
    bit m_job = 1'b0;
    bit m_err = 1'b0;
    int t_clr = 0;
    int t_comp = -1;
    int beats = 0;
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_empty[i] = a_cnt[i] == 0;
            a_full[i] = full_mask[i] || a_cnt[i] >= 8;
        end
    end
    assign b_empty = b_cnt == 0;
    assign b_full = b_cnt >= 8;
    typedef struct packed {
        logic ready, wren, brden, clr, busy, done, err;
        logic [DIM-1:0] rden, mac;
        logic [DIM*DW-1:0] adata;
        logic [DW-1:0] bdata;
    } exp_t;
    // Job timeline: clear at t_clr, beats until DIM accepted, compute k=0.. from t_comp, done at k=2*DIM
    function automatic exp_t model_eval(int c);
        exp_t e = '0;
        int k = c - t_comp;
        bit anyfull = (|a_full) || b_full;
        e.err = m_err;
        if (m_job) begin
            e.busy = 1'b1;
            e.clr = c == t_clr;
            e.ready = c > t_clr && t_comp < 0 && !(host.in_valid && anyfull);
            e.wren = e.ready && host.in_valid;
            if (e.wren) begin
                e.adata = host.in_a_data;
                e.bdata = host.in_b_data;
            end
            if (t_comp >= 0) begin
                for (int i = 0; i < DIM; i++) begin
                    e.rden[i] = k >= i && k < i + DIM;
                    e.mac[i] = k - 1 >= i && k - 1 < i + DIM;
                end
                e.brden = k >= 0 && k < DIM;
                e.done = k == 2*DIM;
            end
        end
        return e;
    endfunction
    always @(posedge clk) begin
        exp_t e;
        e = model_eval(cyc);
        cyc <= cyc + 1;
        if (rst) begin
            m_job <= 1'b0;
            m_err <= 1'b0;
            t_comp <= -1;
            b_cnt <= 0;
            for (int i = 0; i < DIM; i++) a_cnt[i] <= 0;
        end else begin
            b_cnt <= b_cnt + int'(e.wren) - int'(e.brden);
            for (int i = 0; i < DIM; i++) a_cnt[i] <= a_cnt[i] + int'(e.wren) - int'(e.rden[i]);
            if (!m_job) begin
                if (host.start) begin
                    m_job <= 1'b1;
                    t_clr <= cyc + 1;
                    t_comp <= -1;
                    beats <= 0;
                    m_err <= !(&a_empty) || !b_empty;
                end
            end else begin
                if ((cyc > t_clr && t_comp < 0 && host.in_valid && ((|a_full) || b_full)) ||
                    (|(e.rden & a_empty)) || (e.brden && b_empty))
                    m_err <= 1'b1;
                if (e.wren) begin
                    beats <= beats + 1;
                    if (beats + 1 == DIM) t_comp <= cyc + 1;
                end
                if (t_comp >= 0 && cyc - t_comp == 2*DIM) m_job <= 1'b0;
            end
        end
    end
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", n, act, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        e = model_eval(cyc);
        if (cyc > 0) begin
            chk("in_ready", 64'(host.in_ready), 64'(e.ready));
            chk("a_wren", 64'(a_wren), 64'(e.wren));
            chk("b_wren", 64'(b_wren), 64'(e.wren));
            chk("a_wdata", a_wdata, e.adata);
            chk("b_wdata", 64'(b_wdata), 64'(e.bdata));
            chk("a_rden", 64'(a_rden), 64'(e.rden));
            chk("b_rden", 64'(b_rden), 64'(e.brden));
            chk("mac_en", 64'(mac_en), 64'(e.mac));
            chk("mac_clr", 64'(mac_clr), 64'(e.clr));
            chk("busy", 64'(host.busy), 64'(e.busy));
            chk("done", 64'(host.done), 64'(e.done));
            chk("err", 64'(host.err), 64'(e.err));
        end
    end
    int clr_c = -1, rd7_c = -1, mac7_c = -1, done_c = -1, n_wr = 0, n_done = 0;
    always @(negedge clk) begin
        if (mac_clr) begin
            clr_c = cyc;
            rd7_c = -1;
        end
        if (a_rden[DIM-1] && rd7_c < 0) rd7_c = cyc;
        if (mac_en[DIM-1]) mac7_c = cyc;
        if (host.done) begin
            done_c = cyc;
            n_done++;
        end
        if (a_wren) n_wr++;
    end
    task automatic tick();
        @(posedge clk);
        #1;
        host.in_a_data = {$urandom, $urandom};
        host.in_b_data = DW'($urandom);
    endtask
    task automatic start_job(output int t0);
        host.start = 1'b1;
        t0 = cyc;
        tick();
        host.start = 1'b0;
    endtask
    task automatic wait_done(input int d0);
        int n = 0;
        while (n_done == d0 && n < 80) begin
            tick();
            n++;
        end
        chk("done_within_budget", 64'(n < 80), 64'd1);
    endtask
    initial begin
        int t0, t1, w0, d0;
        host.start = 1'b0;
        host.in_valid = 1'b0;
        host.in_a_data = '0;
        host.in_b_data = '0;
        full_mask = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("idle_busy", 64'(host.busy), 64'd0);
        chk("idle_err", 64'(host.err), 64'd0);
        // nominal job, in_valid held high
        host.in_valid = 1'b1;
        w0 = n_wr; d0 = n_done;
        start_job(t0);
        wait_done(d0);
        chk("nom_clr_cycle", 64'(clr_c - t0), 64'd1);
        chk("nom_rden7_first", 64'(rd7_c - t0), 64'd17);
        chk("nom_mac7_last", 64'(mac7_c - t0), 64'd25);
        chk("nom_done_cycle", 64'(done_c - t0), 64'd26);
        chk("nom_writes", 64'(n_wr - w0), 64'd8);
        chk("nom_err", 64'(host.err), 64'd0);
        // three-cycle load stall
        w0 = n_wr; d0 = n_done;
        start_job(t0);
        repeat (4) tick();
        host.in_valid = 1'b0;
        repeat (3) tick();
        host.in_valid = 1'b1;
        wait_done(d0);
        chk("stall_done_cycle", 64'(done_c - t0), 64'd29);
        chk("stall_writes", 64'(n_wr - w0), 64'd8);
        chk("stall_err", 64'(host.err), 64'd0);
        // start and in_valid during COMPUTE are ignored
        w0 = n_wr; d0 = n_done;
        start_job(t0);
        repeat (12) tick();
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        tick();
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        wait_done(d0);
        repeat (5) tick();
        chk("ign_done_count", 64'(n_done - d0), 64'd1);
        chk("ign_writes", 64'(n_wr - w0), 64'd8);
        chk("ign_done_cycle", 64'(done_c - t0), 64'd26);
        chk("ign_busy", 64'(host.busy), 64'd0);
        // full guard on A FIFO 3 for one load cycle
        w0 = n_wr; d0 = n_done;
        start_job(t0);
        repeat (3) tick();
        full_mask[3] = 1'b1;
        @(negedge clk);
        chk("full_in_ready", 64'(host.in_ready), 64'd0);
        chk("full_a_wren", 64'(a_wren), 64'd0);
        tick();
        full_mask = '0;
        chk("full_err_set", 64'(host.err), 64'd1);
        wait_done(d0);
        chk("full_done_cycle", 64'(done_c - t0), 64'd27);
        chk("full_writes", 64'(n_wr - w0), 64'd8);
        repeat (3) tick();
        chk("full_err_sticky", 64'(host.err), 64'd1);
        d0 = n_done;
        start_job(t1);
        chk("full_err_cleared", 64'(host.err), 64'd0);
        wait_done(d0);
        chk("after_full_done", 64'(done_c - t1), 64'd26);
        // reset in the middle of COMPUTE
        start_job(t0);
        repeat (11) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(host.busy), 64'd0);
        chk("rst_a_rden", 64'(a_rden), 64'd0);
        chk("rst_mac_en", 64'(mac_en), 64'd0);
        tick();
        w0 = n_wr; d0 = n_done;
        start_job(t1);
        wait_done(d0);
        chk("post_rst_done", 64'(done_c - t1), 64'd26);
        chk("post_rst_writes", 64'(n_wr - w0), 64'd8);
        chk("post_rst_err", 64'(host.err), 64'd0);
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
